// File: rtl/execute_stage.sv
// EX stage of the single-issue 32-bit MIPS pipeline: operand select, ALU, branch condition,
// branch/jump target formation and destination select, all registered into EX/MEM.
module execute_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegDst,
  input  logic        ALUSrc0,
  input  logic        ALUSrc1,
  input  logic [4:0]  Shamt,
  input  logic [31:0] Reg_Data1,
  input  logic [31:0] Reg_Data2,
  input  logic [31:0] Imm32b,
  input  logic [31:0] PCPlusFour,
  input  logic [5:0]  Instruction,
  input  logic [5:0]  Opcode,
  input  logic [25:0] instr_index,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  output logic        Zero_output,
  output logic [31:0] ALUResult_output,
  output logic [27:0] j_sll_two_output,
  output logic [31:0] PC_Plus_Branch_output,
  output logic [4:0]  RegDestSelected_output
);

  localparam logic [5:0] OpRtype    = 6'h00;
  localparam logic [5:0] OpRegimm   = 6'h01;
  localparam logic [5:0] OpJ        = 6'h02;
  localparam logic [5:0] OpJal      = 6'h03;
  localparam logic [5:0] OpBeq      = 6'h04;
  localparam logic [5:0] OpBne      = 6'h05;
  localparam logic [5:0] OpBlez     = 6'h06;
  localparam logic [5:0] OpBgtz     = 6'h07;
  localparam logic [5:0] OpAddi     = 6'h08;
  localparam logic [5:0] OpAddiu    = 6'h09;
  localparam logic [5:0] OpSlti     = 6'h0A;
  localparam logic [5:0] OpSltiu    = 6'h0B;
  localparam logic [5:0] OpAndi     = 6'h0C;
  localparam logic [5:0] OpOri      = 6'h0D;
  localparam logic [5:0] OpXori     = 6'h0E;
  localparam logic [5:0] OpLui      = 6'h0F;
  localparam logic [5:0] OpSpecial2 = 6'h1C;
  localparam logic [5:0] OpLb       = 6'h20;
  localparam logic [5:0] OpLh       = 6'h21;
  localparam logic [5:0] OpLw       = 6'h23;
  localparam logic [5:0] OpSb       = 6'h28;
  localparam logic [5:0] OpSh       = 6'h29;
  localparam logic [5:0] OpSw       = 6'h2B;

  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_zimm;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_mul;
  logic        w_slt;
  logic        w_sltu;
  logic [31:0] w_result;
  logic        w_is_branch;
  logic        w_branch_cond;
  logic        w_zero;

  logic        r_zero;
  logic [31:0] r_result;
  logic [27:0] r_jsll;
  logic [31:0] r_pcb;
  logic [4:0]  r_dst;

  assign w_a    = ALUSrc0 ? {27'b0, Shamt} : Reg_Data1;
  assign w_b    = ALUSrc1 ? Imm32b : Reg_Data2;
  assign w_zimm = {16'b0, Imm32b[15:0]};
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  // Low 32 bits of a product are identical for signed and unsigned operands.
  assign w_mul  = w_a * w_b;
  assign w_slt  = $signed(w_a) < $signed(w_b);
  assign w_sltu = w_a < w_b;

  always_comb begin
    w_result      = '0;
    w_is_branch   = 1'b0;
    w_branch_cond = 1'b0;
    case (Instruction)
      OpRtype: begin
        case (Opcode)
          6'h20, 6'h21: w_result = w_sum;
          6'h22, 6'h23: w_result = w_diff;
          6'h24:        w_result = w_a & w_b;
          6'h25:        w_result = w_a | w_b;
          6'h26:        w_result = w_a ^ w_b;
          6'h27:        w_result = ~(w_a | w_b);
          6'h2A:        w_result = {31'b0, w_slt};
          6'h2B:        w_result = {31'b0, w_sltu};
          6'h00, 6'h04: w_result = w_b << w_a[4:0];
          6'h02, 6'h06: w_result = w_b >> w_a[4:0];
          6'h03, 6'h07: w_result = $signed(w_b) >>> w_a[4:0];
          6'h08:        w_result = w_a;
          default:      w_result = '0;
        endcase
      end
      OpSpecial2: w_result = (Opcode == 6'h02) ? w_mul : '0;
      OpAddi, OpAddiu, OpLb, OpLh, OpLw, OpSb, OpSh, OpSw: w_result = w_sum;
      OpSlti:   w_result = {31'b0, w_slt};
      OpSltiu:  w_result = {31'b0, w_sltu};
      OpAndi:   w_result = w_a & w_zimm;
      OpOri:    w_result = w_a | w_zimm;
      OpXori:   w_result = w_a ^ w_zimm;
      OpLui:    w_result = {Imm32b[15:0], 16'b0};
      OpJ, OpJal: w_result = PCPlusFour;
      OpBeq: begin
        w_result      = w_diff;
        w_is_branch   = 1'b1;
        w_branch_cond = (w_a == w_b);
      end
      OpBne: begin
        w_result      = w_diff;
        w_is_branch   = 1'b1;
        w_branch_cond = (w_a != w_b);
      end
      OpBgtz: begin
        w_result      = w_diff;
        w_is_branch   = 1'b1;
        w_branch_cond = !w_a[31] && (w_a != '0);
      end
      OpBlez: begin
        w_result      = w_diff;
        w_is_branch   = 1'b1;
        w_branch_cond = w_a[31] || (w_a == '0);
      end
      OpRegimm: begin
        // rt==1 is bgez, anything else is treated as bltz.
        w_result      = w_diff;
        w_is_branch   = 1'b1;
        w_branch_cond = (rt == 5'd1) ? !w_a[31] : w_a[31];
      end
      default: w_result = '0;
    endcase
  end

  assign w_zero = w_is_branch ? w_branch_cond : (w_result == '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_zero   <= 1'b0;
      r_result <= '0;
      r_jsll   <= '0;
      r_pcb    <= '0;
      r_dst    <= '0;
    end else begin
      r_zero   <= w_zero;
      r_result <= w_result;
      r_jsll   <= {instr_index, 2'b00};
      r_pcb    <= PCPlusFour + {Imm32b[29:0], 2'b00};
      r_dst    <= RegDst ? rd : rt;
    end
  end

  assign Zero_output            = r_zero;
  assign ALUResult_output       = r_result;
  assign j_sll_two_output       = r_jsll;
  assign PC_Plus_Branch_output  = r_pcb;
  assign RegDestSelected_output = r_dst;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: a table of hand-computed operations plus reset,
// reset-priority and one-cycle-latency sequences.
module tb_execute_stage;

  typedef struct packed {
    logic        regdst;
    logic        src0;
    logic        src1;
    logic [4:0]  shamt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [5:0]  instr;
    logic [5:0]  funct;
    logic [25:0] idx;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        ezero;
    logic [31:0] eres;
    logic [27:0] ejsl;
    logic [31:0] epcb;
    logic [4:0]  edst;
  } vec_t;

  localparam int NumVec = 25;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegDst, ALUSrc0, ALUSrc1;
  logic [4:0]  Shamt, rt, rd;
  logic [31:0] Reg_Data1, Reg_Data2, Imm32b, PCPlusFour;
  logic [5:0]  Instruction, Opcode;
  logic [25:0] instr_index;
  logic        Zero_output;
  logic [31:0] ALUResult_output;
  logic [27:0] j_sll_two_output;
  logic [31:0] PC_Plus_Branch_output;
  logic [4:0]  RegDestSelected_output;

  vec_t vecs [NumVec];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 Clk = ~Clk;

  execute_stage dut (
    .Clk                    (Clk),
    .Reset                  (Reset),
    .RegDst                 (RegDst),
    .ALUSrc0                (ALUSrc0),
    .ALUSrc1                (ALUSrc1),
    .Shamt                  (Shamt),
    .Reg_Data1              (Reg_Data1),
    .Reg_Data2              (Reg_Data2),
    .Imm32b                 (Imm32b),
    .PCPlusFour             (PCPlusFour),
    .Instruction            (Instruction),
    .Opcode                 (Opcode),
    .instr_index            (instr_index),
    .rt                     (rt),
    .rd                     (rd),
    .Zero_output            (Zero_output),
    .ALUResult_output       (ALUResult_output),
    .j_sll_two_output       (j_sll_two_output),
    .PC_Plus_Branch_output  (PC_Plus_Branch_output),
    .RegDestSelected_output (RegDestSelected_output)
  );

  task automatic apply(input vec_t v);
    RegDst      = v.regdst;
    ALUSrc0     = v.src0;
    ALUSrc1     = v.src1;
    Shamt       = v.shamt;
    Reg_Data1   = v.rd1;
    Reg_Data2   = v.rd2;
    Imm32b      = v.imm;
    PCPlusFour  = v.pc4;
    Instruction = v.instr;
    Opcode      = v.funct;
    instr_index = v.idx;
    rt          = v.rt;
    rd          = v.rd;
  endtask

  task automatic check(input string name, input logic ez, input logic [31:0] er,
                       input logic [27:0] ej, input logic [31:0] ep, input logic [4:0] ed);
    n_vec++;
    if (Zero_output !== ez) begin
      n_bad++;
      $display("FAIL %s zero: got %0b want %0b", name, Zero_output, ez);
    end
    if (ALUResult_output !== er) begin
      n_bad++;
      $display("FAIL %s result: got %h want %h", name, ALUResult_output, er);
    end
    if (j_sll_two_output !== ej) begin
      n_bad++;
      $display("FAIL %s j_sll_two: got %h want %h", name, j_sll_two_output, ej);
    end
    if (PC_Plus_Branch_output !== ep) begin
      n_bad++;
      $display("FAIL %s pc_branch: got %h want %h", name, PC_Plus_Branch_output, ep);
    end
    if (RegDestSelected_output !== ed) begin
      n_bad++;
      $display("FAIL %s dest: got %0d want %0d", name, RegDestSelected_output, ed);
    end
  endtask

  task automatic check_vec(input string name, input vec_t v);
    check(name, v.ezero, v.eres, v.ejsl, v.epcb, v.edst);
  endtask

  initial begin
    // regdst src0 src1 shamt rd1 rd2 imm pc4 instr funct idx rt rd | zero res jsll pcb dst
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'd108, 32'd112, 32'd15, 32'd4, 6'h00, 6'h20,
                 26'h0FFFFFF, 5'd0, 5'd16, 1'b0, 32'd220, 28'h3FFFFFC, 32'd64, 5'd16};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h0000000F, 32'h0, 32'h0, 6'h00, 6'h00,
                 26'h0, 5'd0, 5'd3, 1'b0, 32'h000000F0, 28'h0, 32'h0, 5'd3};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h80000000, 32'h0, 32'h0, 6'h00, 6'h03,
                 26'h0, 5'd0, 5'd3, 1'b0, 32'hF8000000, 28'h0, 32'h0, 5'd3};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'd4, 32'h0, 32'h80000000, 32'h0, 32'h0, 6'h00, 6'h02,
                 26'h0, 5'd0, 5'd3, 1'b0, 32'h08000000, 28'h0, 32'h0, 5'd3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h24, 32'h80000000, 32'h0, 32'h0, 6'h00, 6'h07,
                 26'h0, 5'd0, 5'd4, 1'b0, 32'hF8000000, 28'h0, 32'h0, 5'd4};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'd5, 32'd7, 32'h0, 32'h0, 6'h00, 6'h22,
                 26'h0, 5'd0, 5'd5, 1'b0, 32'hFFFFFFFE, 28'h0, 32'h0, 5'd5};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0, 32'h0, 6'h00,
                 6'h27, 26'h0, 5'd0, 5'd6, 1'b0, 32'hF000F000, 28'h0, 32'h0, 5'd6};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 6'h00, 6'h2A,
                 26'h0, 5'd0, 5'd7, 1'b0, 32'd1, 28'h0, 32'h0, 5'd7};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 6'h00, 6'h2B,
                 26'h0, 5'd0, 5'd8, 1'b1, 32'd0, 28'h0, 32'h0, 5'd8};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h0, 6'h08, 6'h00,
                 26'h0, 5'd9, 5'd20, 1'b1, 32'd0, 28'h0, 32'hFFFFFFFC, 5'd9};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 32'h0, 32'h00001234, 32'h0, 6'h0F, 6'h00,
                 26'h0, 5'd2, 5'd21, 1'b0, 32'h12340000, 28'h0, 32'h000048D0, 5'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFF8001, 32'h0, 6'h0C,
                 6'h00, 26'h0, 5'd10, 5'd0, 1'b0, 32'h00008001, 28'h0, 32'hFFFE0004, 5'd10};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h12340000, 32'h0, 32'hFFFF8000, 32'h0, 6'h0D,
                 6'h00, 26'h0, 5'd11, 5'd0, 1'b0, 32'h12348000, 28'h0, 32'hFFFE0000, 5'd11};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd5, 32'd5, 32'hFFFFFFFE, 32'd100, 6'h04, 6'h00,
                 26'h0, 5'd0, 5'd0, 1'b1, 32'd0, 28'h0, 32'd92, 5'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd5, 32'd5, 32'hFFFFFFFE, 32'd100, 6'h05, 6'h00,
                 26'h0, 5'd0, 5'd0, 1'b0, 32'd0, 28'h0, 32'd92, 5'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0, 6'h07, 6'h00,
                 26'h0, 5'd0, 5'd0, 1'b0, 32'd0, 28'h0, 32'h0, 5'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd0, 32'h0, 32'h0, 6'h06, 6'h00,
                 26'h0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 28'h0, 32'h0, 5'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd0, 32'h0, 32'h0, 6'h01, 6'h00,
                 26'h0, 5'd1, 5'd0, 1'b0, 32'hFFFFFFFF, 28'h0, 32'h0, 5'd1};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, 32'd0, 32'h0, 32'h0, 6'h01, 6'h00,
                 26'h0, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF, 28'h0, 32'h0, 5'd0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFD, 32'd7, 32'h0, 32'h0, 6'h1C, 6'h02,
                 26'h0, 5'd0, 5'd12, 1'b0, 32'hFFFFFFEB, 28'h0, 32'h0, 5'd12};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h00400010, 6'h03, 6'h00,
                 26'h3FFFFFF, 5'd31, 5'd0, 1'b0, 32'h00400010, 28'hFFFFFFC, 32'h00400010, 5'd31};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 6'h00, 6'h08,
                 26'h0, 5'd0, 5'd0, 1'b0, 32'hDEADBEEF, 28'h0, 32'h0, 5'd0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 6'h3F,
                 6'h20, 26'h0, 5'd0, 5'd13, 1'b1, 32'd0, 28'h0, 32'h0, 5'd13};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 5'd0, 32'h00001000, 32'h0, 32'h00000010, 32'h0, 6'h23,
                 6'h00, 26'h0, 5'd14, 5'd0, 1'b0, 32'h00001010, 28'h0, 32'h00000040, 5'd14};
    vecs[24] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 32'h0, 6'h00,
                 6'h26, 26'h0, 5'd0, 5'd15, 1'b0, 32'hF0F0F0F0, 28'h0, 32'h0, 5'd15};

    // Reset held for two edges with live inputs must keep every output at zero.
    Reset = 1'b1;
    apply(vecs[0]);
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk);
      #1;
      check($sformatf("reset%0d", c), 1'b0, 32'h0, 28'h0, 32'h0, 5'd0);
    end
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_vec("post_reset_add", vecs[0]);

    for (int i = 0; i < NumVec; i++) begin
      @(negedge Clk);
      apply(vecs[i]);
      @(posedge Clk);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Outputs must hold the previous result until the next edge.
    @(negedge Clk);
    apply(vecs[0]);
    #1;
    check_vec("latency_hold", vecs[NumVec-1]);
    @(posedge Clk);
    #1;
    check_vec("latency_update", vecs[0]);

    // Reset wins over new data arriving on the same edge.
    @(negedge Clk);
    Reset = 1'b1;
    apply(vecs[20]);
    @(posedge Clk);
    #1;
    check("reset_priority", 1'b0, 32'h0, 28'h0, 32'h0, 5'd0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check_vec("reset_release_jal", vecs[20]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
